// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared state type and width helper for the FIFO word packer
package sfifo_pkg;

  // FILL gathers words into lanes; SEALED waits for the output slot to drain
  typedef enum logic {
    FILL   = 1'b0,
    SEALED = 1'b1
  } pack_state_e;

  // Lane counter must hold 0..ratio inclusive
  function automatic int lane_cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/sfifo_packer_if.sv
// rtl/sfifo_packer_if.sv - packed-beat valid/ready stream between packer and consumer
interface sfifo_packer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);

  logic [IN_WIDTH*RATIO-1:0] m_data;
  logic [RATIO-1:0]          m_keep;
  logic                      m_last;
  logic                      m_valid;
  logic                      m_ready;

  modport master (
    output m_data,
    output m_keep,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_keep,
    input  m_last,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/sfifo_pack_timer.sv
// rtl/sfifo_pack_timer.sv - idle counter that flags when a partial beat should be sealed
module sfifo_pack_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // A zero TIMEOUT still needs a one-bit register so the ports stay legal
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned EXP_VAL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Clear wins over count; counting is suppressed entirely when the timeout is disabled
  always_comb begin
    timer_d = timer_q;
    if (i_clr) begin
      timer_d = '0;
    end else if (i_en && (TIMEOUT > 0)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Idle-cycle register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign o_expired = (TIMEOUT > 0) && (timer_q == TW'(EXP_VAL));

endmodule

// File: rtl/sfifo_packer.sv
// rtl/sfifo_packer.sv - pops narrow FIFO words and packs RATIO of them into one wide beat
module sfifo_packer
  import sfifo_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_fifo_rd_en,
  input  logic [IN_WIDTH-1:0] i_fifo_data,
  input  logic                i_fifo_empty,
  input  logic                i_flush,
  sfifo_packer_if.master      m,
  output logic                o_busy
);

  localparam int OW = IN_WIDTH * RATIO;
  localparam int CW = lane_cnt_width(RATIO);

  pack_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    lanes_q, lanes_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             last_r_q, last_r_d;
  logic [OW-1:0]    m_data_q, m_data_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;
  logic             m_last_q, m_last_d;
  logic             m_valid_q, m_valid_d;

  logic flush_eff;
  logic rd_en;
  logic slot_free;
  logic load;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  // Handshake decode: a flush on an empty accumulation is a no-op, and a flush cycle never pops
  always_comb begin
    flush_eff = i_flush & (cnt_q != '0);
    rd_en     = i_rst_n & (state_q == FILL) & ~i_fifo_empty & ~flush_eff;
    slot_free = ~m_valid_q | m.m_ready;
    load      = (state_q == SEALED) & slot_free;
    tmr_en    = (state_q == FILL) & (cnt_q != '0) & ~rd_en;
    tmr_clr   = load | ((state_q == FILL) & (rd_en | (cnt_q == '0)));
  end

  sfifo_pack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (tmr_clr),
    .i_en      (tmr_en),
    .o_expired (tmr_expired)
  );

  // Next-state for the accumulator FSM and the registered output slot
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lanes_d   = lanes_q;
    keep_d    = keep_q;
    last_r_d  = last_r_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;

    // Accepted beat leaves the slot unless a new one replaces it below
    if (m_valid_q && m.m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (rd_en) begin
          for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CW'(i)) begin
              lanes_d[i*IN_WIDTH +: IN_WIDTH] = i_fifo_data;
              keep_d[i]                       = 1'b1;
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(RATIO - 1)) begin
            state_d  = SEALED;
            last_r_d = 1'b0;
          end
        end else if (flush_eff || (tmr_expired && (cnt_q != '0))) begin
          state_d  = SEALED;
          last_r_d = 1'b1;
        end
      end
      SEALED: begin
        if (load) begin
          m_data_d  = lanes_q;
          m_keep_d  = keep_q;
          m_last_d  = last_r_q;
          m_valid_d = 1'b1;
          lanes_d   = '0;
          keep_d    = '0;
          cnt_d     = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and output registers; reset drops any partial accumulation and any held beat
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      lanes_q   <= '0;
      keep_q    <= '0;
      last_r_q  <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lanes_q   <= lanes_d;
      keep_q    <= keep_d;
      last_r_q  <= last_r_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign o_fifo_rd_en = rd_en;
  assign m.m_data     = m_data_q;
  assign m.m_keep     = m_keep_q;
  assign m.m_last     = m_last_q;
  assign m.m_valid    = m_valid_q;
  assign o_busy       = (cnt_q != '0) | (state_q == SEALED) | m_valid_q;

endmodule
